// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC / IF-ID / ID-EX sequencing for the 5-stage pipeline.
// Handles load-use stalls, taken-branch flushes, halt drain and perf counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [4:0]       ID_RSAddr,
    input  logic [4:0]       ID_RTAddr,
    input  logic             ID_UsesRT,
    input  logic             ID_Halt,
    input  logic             EX_RegWriteEN,
    input  logic             EX_Mem2RegSEL,
    input  logic [4:0]       EX_DstAddr,
    input  logic             EX_BranchTaken,
    output logic             PCWriteEN,
    output logic             IFIDWriteEN,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             Done,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_HALTED
    } state_t;

    // Reload values exclude the cycle that enters STALL/DRAIN
    localparam logic [3:0] STALL_INIT =
        4'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);
    localparam logic [3:0] DRAIN_INIT =
        4'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_run;
    logic w_stall_inc;
    logic w_flush_inc;

    // Load in EX whose destination feeds an ID source operand
    always_comb begin
        w_lu = EX_Mem2RegSEL && EX_RegWriteEN && (EX_DstAddr != 5'd0) &&
               ((EX_DstAddr == ID_RSAddr) ||
                (ID_UsesRT && (EX_DstAddr == ID_RTAddr)));
    end

    // Counter increment qualifiers; branch outranks halt and hazard
    always_comb begin
        w_run       = (r_state == S_RUN);
        w_flush_inc = w_run && EX_BranchTaken;
        w_stall_inc = (w_run && !EX_BranchTaken && !ID_Halt && w_lu) ||
                      (r_state == S_STALL);
    end

    // Mealy outputs in RUN, Moore elsewhere; reset forces a safe hold
    always_comb begin
        PCWriteEN   = 1'b0;
        IFIDWriteEN = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b1;
        Done        = 1'b0;
        if (RESET) begin
            IFIDFlush = 1'b1;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (EX_BranchTaken) begin
                        PCWriteEN = 1'b1;
                        IFIDWriteEN = 1'b1;
                        IFIDFlush = 1'b1;
                    end else if (!ID_Halt && !w_lu) begin
                        PCWriteEN   = 1'b1;
                        IFIDWriteEN = 1'b1;
                        IDEXBubble  = 1'b0;
                    end
                end
                S_STALL, S_DRAIN: begin
                end
                S_HALTED: Done = 1'b1;
            endcase
        end
    end

    // State, shared down-counter and saturating performance counters
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= S_RUN;
            r_cnt       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc && r_flush_cnt != CNT_MAX)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            unique case (r_state)
                S_RUN: begin
                    if (EX_BranchTaken) begin
                        r_state <= S_RUN;
                    end else if (ID_Halt) begin
                        if (DRAIN_CYCLES == 1) begin
                            r_state <= S_HALTED;
                        end else begin
                            r_cnt   <= DRAIN_INIT;
                            r_state <= S_DRAIN;
                        end
                    end else if (w_lu && LOAD_STALL > 1) begin
                        r_cnt   <= STALL_INIT;
                        r_state <= S_STALL;
                    end
                end
                S_STALL: begin
                    if (r_cnt == 4'd0) r_state <= S_RUN;
                    else r_cnt <= r_cnt - 4'd1;
                end
                S_DRAIN: begin
                    if (r_cnt == 4'd0) r_state <= S_HALTED;
                    else r_cnt <= r_cnt - 4'd1;
                end
                S_HALTED: r_state <= S_HALTED;
            endcase
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors and multi-cycle sequences
// for three parameterisations of pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [4:0] ID_RSAddr, ID_RTAddr, EX_DstAddr;
    logic       ID_UsesRT, ID_Halt, EX_RegWriteEN, EX_Mem2RegSEL;
    logic       EX_BranchTaken;

    // a: LOAD_STALL=1, DRAIN=3; b: LOAD_STALL=3; c: CNT_W=4, DRAIN=1
    logic        pcw_a, ifw_a, fl_a, bub_a, done_a;
    logic [15:0] sc_a, fc_a;
    logic        pcw_b, ifw_b, fl_b, bub_b, done_b;
    logic [15:0] sc_b, fc_b;
    logic        pcw_c, ifw_c, fl_c, bub_c, done_c;
    logic [3:0]  sc_c, fc_c;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    pipe_hazard_ctrl #(.LOAD_STALL(1), .DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET),
        .ID_RSAddr(ID_RSAddr), .ID_RTAddr(ID_RTAddr),
        .ID_UsesRT(ID_UsesRT), .ID_Halt(ID_Halt),
        .EX_RegWriteEN(EX_RegWriteEN), .EX_Mem2RegSEL(EX_Mem2RegSEL),
        .EX_DstAddr(EX_DstAddr), .EX_BranchTaken(EX_BranchTaken),
        .PCWriteEN(pcw_a), .IFIDWriteEN(ifw_a), .IFIDFlush(fl_a),
        .IDEXBubble(bub_a), .Done(done_a),
        .StallCount(sc_a), .FlushCount(fc_a)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(3), .DRAIN_CYCLES(3), .CNT_W(16)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET),
        .ID_RSAddr(ID_RSAddr), .ID_RTAddr(ID_RTAddr),
        .ID_UsesRT(ID_UsesRT), .ID_Halt(ID_Halt),
        .EX_RegWriteEN(EX_RegWriteEN), .EX_Mem2RegSEL(EX_Mem2RegSEL),
        .EX_DstAddr(EX_DstAddr), .EX_BranchTaken(EX_BranchTaken),
        .PCWriteEN(pcw_b), .IFIDWriteEN(ifw_b), .IFIDFlush(fl_b),
        .IDEXBubble(bub_b), .Done(done_b),
        .StallCount(sc_b), .FlushCount(fc_b)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(1), .DRAIN_CYCLES(1), .CNT_W(4)) dut_c (
        .CLOCK(CLOCK), .RESET(RESET),
        .ID_RSAddr(ID_RSAddr), .ID_RTAddr(ID_RTAddr),
        .ID_UsesRT(ID_UsesRT), .ID_Halt(ID_Halt),
        .EX_RegWriteEN(EX_RegWriteEN), .EX_Mem2RegSEL(EX_Mem2RegSEL),
        .EX_DstAddr(EX_DstAddr), .EX_BranchTaken(EX_BranchTaken),
        .PCWriteEN(pcw_c), .IFIDWriteEN(ifw_c), .IFIDFlush(fl_c),
        .IDEXBubble(bub_c), .Done(done_c),
        .StallCount(sc_c), .FlushCount(fc_c)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
        logic       regw;
        logic       m2r;
        logic [4:0] dst;
        logic       br;
        logic       e_pcw;
        logic       e_ifw;
        logic       e_fl;
        logic       e_bub;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_in();
        ID_RSAddr = 0; ID_RTAddr = 0; ID_UsesRT = 0; ID_Halt = 0;
        EX_RegWriteEN = 0; EX_Mem2RegSEL = 0; EX_DstAddr = 0;
        EX_BranchTaken = 0;
    endtask

    // advance one clock; inputs for the next cycle are applied after
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        RESET = 1;
        tick();
        RESET = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        EX_Mem2RegSEL = 1; EX_RegWriteEN = 1;
        EX_DstAddr = r; ID_RSAddr = r;
    endtask

    initial begin
        int exp_sc;
        int exp_fc;

        tbl[0] = '{5'd1, 5'd2, 1, 1, 0, 5'd5, 0, 1, 1, 0, 0};
        tbl[1] = '{5'd5, 5'd2, 0, 1, 1, 5'd5, 0, 0, 0, 0, 1};
        tbl[2] = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 1, 1, 0, 0};
        tbl[3] = '{5'd5, 5'd5, 1, 0, 1, 5'd5, 0, 1, 1, 0, 0};
        tbl[4] = '{5'd3, 5'd9, 1, 1, 1, 5'd9, 0, 0, 0, 0, 1};
        tbl[5] = '{5'd3, 5'd9, 0, 1, 1, 5'd9, 0, 1, 1, 0, 0};
        tbl[6] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, 1, 1};
        tbl[7] = '{5'd5, 5'd5, 1, 1, 1, 5'd5, 1, 1, 1, 1, 1};
        tbl[8] = '{5'd7, 5'd0, 0, 1, 1, 5'd7, 0, 0, 0, 0, 1};

        // reset state and forced reset outputs
        clr_in();
        RESET = 1;
        #2;
        chk("rst_pcw", pcw_a, 0);
        chk("rst_ifw", ifw_a, 0);
        chk("rst_flush", fl_a, 1);
        chk("rst_bub", bub_a, 1);
        chk("rst_done", done_a, 0);
        tick();
        RESET = 0;
        #1;
        chk("rst_sc", sc_a, 0);
        chk("rst_fc", fc_a, 0);
        chk("rst_run_pcw", pcw_a, 1);

        // combinational RUN response, LOAD_STALL=1
        exp_sc = 0;
        exp_fc = 0;
        for (int i = 0; i < 9; i++) begin
            ID_RSAddr = tbl[i].rs; ID_RTAddr = tbl[i].rt;
            ID_UsesRT = tbl[i].usesrt; ID_Halt = 0;
            EX_RegWriteEN = tbl[i].regw; EX_Mem2RegSEL = tbl[i].m2r;
            EX_DstAddr = tbl[i].dst; EX_BranchTaken = tbl[i].br;
            #2;
            chk($sformatf("v%0d_pcw", i), pcw_a, tbl[i].e_pcw);
            chk($sformatf("v%0d_ifw", i), ifw_a, tbl[i].e_ifw);
            chk($sformatf("v%0d_flush", i), fl_a, tbl[i].e_fl);
            chk($sformatf("v%0d_bub", i), bub_a, tbl[i].e_bub);
            chk($sformatf("v%0d_done", i), done_a, 0);
            if (tbl[i].e_fl) exp_fc++;
            else if (tbl[i].e_bub) exp_sc++;
            tick();
        end
        clr_in();
        #1;
        chk("tbl_sc", sc_a, exp_sc);
        chk("tbl_fc", fc_a, exp_fc);

        // LOAD_STALL=3 hazard via rt: three-cycle hold
        do_reset();
        EX_Mem2RegSEL = 1; EX_RegWriteEN = 1; EX_DstAddr = 9;
        ID_UsesRT = 1; ID_RTAddr = 9; ID_RSAddr = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("ls3_c%0d_pcw", c), pcw_b, (c < 3) ? 0 : 1);
            chk($sformatf("ls3_c%0d_bub", c), bub_b, (c < 3) ? 1 : 0);
            tick();
            clr_in();
        end
        chk("ls3_sc", sc_b, 3);
        EX_Mem2RegSEL = 1; EX_RegWriteEN = 1; EX_DstAddr = 9;
        ID_UsesRT = 0; ID_RTAddr = 9; ID_RSAddr = 1;
        #1;
        chk("ls3_nort_pcw", pcw_b, 1);
        tick();
        clr_in();
        #1;
        chk("ls3_nort_sc", sc_b, 3);

        // branch beats simultaneous halt and load-use
        do_reset();
        set_lu(5'd5);
        ID_Halt = 1; EX_BranchTaken = 1;
        #1;
        chk("br_flush", fl_a, 1);
        chk("br_bub", bub_a, 1);
        chk("br_pcw", pcw_a, 1);
        chk("br_ifw", ifw_a, 1);
        tick();
        clr_in();
        #1;
        chk("br_next_pcw", pcw_a, 1);
        chk("br_next_flush", fl_a, 0);
        chk("br_fc", fc_a, 1);
        chk("br_sc", sc_a, 0);
        chk("br_b_pcw", pcw_b, 1);
        tick();
        chk("br_no_drain_done", done_a, 0);
        chk("br_no_drain_c", done_c, 0);

        // halt drain: DRAIN=3 on a, DRAIN=1 on c
        do_reset();
        ID_Halt = 1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) EX_BranchTaken = 1;
            #1;
            chk($sformatf("halt_c%0d_done", c), done_a, (c >= 3) ? 1 : 0);
            chk($sformatf("halt_c%0d_pcw", c), pcw_a, 0);
            chk($sformatf("halt_c%0d_flush", c), fl_a, 0);
            chk($sformatf("halt1_c%0d_done", c), done_c, (c >= 1) ? 1 : 0);
            tick();
            clr_in();
        end
        chk("halt_fc", fc_a, 0);

        // reset on second cycle of a three-cycle stall
        do_reset();
        set_lu(5'd4);
        #1;
        chk("rs_c0_pcw", pcw_b, 0);
        tick();
        clr_in();
        RESET = 1;
        #1;
        chk("rs_c1_pcw", pcw_b, 0);
        chk("rs_c1_ifw", ifw_b, 0);
        chk("rs_c1_flush", fl_b, 1);
        chk("rs_c1_bub", bub_b, 1);
        chk("rs_c1_done", done_b, 0);
        tick();
        RESET = 0;
        #1;
        chk("rs_c2_pcw", pcw_b, 1);
        chk("rs_c2_bub", bub_b, 0);
        chk("rs_c2_sc", sc_b, 0);
        chk("rs_c2_fc", fc_b, 0);

        // CNT_W=4 flush counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            EX_BranchTaken = 1;
            tick();
            if (i == 13) chk("sat_14", fc_c, 14);
        end
        clr_in();
        chk("sat_15", fc_c, 15);
        chk("sat_a", fc_a, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. It drives the PC, IF/ID and ID/EX stage registers.
- Detects load-use hazards and holds the front end for a parameterised number of cycles.
- Flushes wrong-path instructions when a branch resolves taken in EX.
- On a halt instruction, drains the pipeline and then freezes it.
- Keeps saturating stall and flush counters for performance debug.

## Interface
- LOAD_STALL, 1: cycles the front end holds per load-use hazard (1..15).
- DRAIN_CYCLES, 3: cycles between halt decode and Done (1..15).
- CNT_W, 16: width of the performance counters.

Ports:
- CLOCK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- ID_RSAddr  in  5  rs field of the instruction in ID.
- ID_RTAddr  in  5  rt field of the instruction in ID.
- ID_UsesRT  in  1  instruction in ID reads rt as a source.
- ID_Halt  in  1  instruction in ID is the halt encoding.
- EX_RegWriteEN  in  1  RegWriteEN_Out of the ID/EX register.
- EX_Mem2RegSEL  in  1  Mem2RegSEL_Out of the ID/EX register (load in EX).
- EX_DstAddr  in  5  destination register selected in EX (after the RegDst mux).
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
- PCWriteEN  out  1  PC register update enable.
- IFIDWriteEN  out  1  IF/ID register update enable.
- IFIDFlush  out  1  IF/ID register loads a NOP.
- IDEXBubble  out  1  ID/EX register loads all control bits as 0.
- Done  out  1  pipeline halted and drained.
- StallCount  out  CNT_W  load-use stall cycles, saturating.
- FlushCount  out  CNT_W  branch flushes, saturating.

## Operation

States: RUN, STALL, DRAIN, HALTED. A 4-bit down-counter `cnt` serves STALL and DRAIN.

Load-use hazard (`lu`):
- Condition: EX_Mem2RegSEL && EX_RegWriteEN && EX_DstAddr != 0 && (EX_DstAddr == ID_RSAddr || (ID_UsesRT && EX_DstAddr == ID_RTAddr)).

RUN (default outputs PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=0, IDEXBubble=0). Input priority, highest first:
1. EX_BranchTaken:
   - Outputs: IFIDFlush=1, IDEXBubble=1, PCWriteEN=1 (PC takes the target).
   - FlushCount += 1. Remain in RUN.
   - Any simultaneous ID_Halt or lu is ignored (wrong path).
2. ID_Halt:
   - Outputs: PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1.
   - If DRAIN_CYCLES == 1, go to HALTED; otherwise cnt = DRAIN_CYCLES-2 and go to DRAIN.
3. lu:
   - Outputs: PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1. StallCount += 1.
   - If LOAD_STALL > 1: cnt = LOAD_STALL-2 and go to STALL; otherwise remain in RUN.

STALL:
- Outputs: PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1. StallCount += 1.
- EX_BranchTaken and ID inputs are ignored.
- When cnt == 0, go to RUN; otherwise cnt -= 1.

DRAIN:
- Outputs identical to STALL. Counters hold. Inputs are ignored.
- When cnt == 0, go to HALTED; otherwise cnt -= 1.

HALTED:
- Outputs: PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1, Done=1.
- Terminal state; only RESET leaves it.

General rules:
- Done=1 only in HALTED.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Outputs are combinational from state plus inputs (Mealy in RUN, Moore elsewhere). Zero-cycle reaction to hazards and branches.
- Load-use: the front end is held for exactly LOAD_STALL consecutive cycles, starting the cycle lu is seen.
- Branch flush: a single cycle; the next cycle is normal RUN.
- Halt: Done rises exactly DRAIN_CYCLES cycles after the ID_Halt cycle. For example, halt seen in cycle 0 with DRAIN_CYCLES=3 gives Done=1 from cycle 3.
- RESET high:
  - Outputs are forced to PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXBubble=1, Done=0.
  - Next state is RUN, cnt=0, StallCount=0, FlushCount=0.
  - Reset from any state, including mid-STALL or HALTED, behaves identically.
- After RESET falls, the first cycle uses RUN behaviour.

## Test plan
1. Load-use, LOAD_STALL=1. Inputs: EX_Mem2RegSEL=1, EX_RegWriteEN=1, EX_DstAddr=5, ID_RSAddr=5 for one cycle. Required: PCWriteEN=0 and IDEXBubble=1 for exactly 1 cycle; StallCount=1. Repeat with EX_DstAddr=0: no stall.
2. LOAD_STALL=3, hazard via rt: ID_UsesRT=1, ID_RTAddr=9, EX_DstAddr=9. Required: 3-cycle hold, StallCount=3. Repeat with ID_UsesRT=0: no stall.
3. EX_BranchTaken=1 in the same cycle as lu and ID_Halt. Required: IFIDFlush=1, IDEXBubble=1, PCWriteEN=1 for 1 cycle; FlushCount=1; StallCount unchanged; no DRAIN entry.
4. ID_Halt, DRAIN_CYCLES=3, halt in cycle 0. Required: Done=0 in cycles 0-2, Done=1 from cycle 3 onward; PCWriteEN=0 throughout; a later EX_BranchTaken is ignored.
5. RESET asserted on the second cycle of a 3-cycle STALL. Required: forced reset outputs that cycle; next cycle RUN with PCWriteEN=1 and counters 0.
6. CNT_W=4, 20 single-cycle branch flushes. Required: FlushCount saturates at 15.
